// File: rtl/mem_tag_remap.sv
// Read-tag compactor between the memory arbiter and the memory port: wide
// upstream tags are parked in a slot table and replaced by a free slot index.
module mem_tag_remap #(
  parameter  int ADDR_WIDTH   = 26,
  parameter  int DATA_SIZE    = 64,
  parameter  int IN_TAG_WIDTH = 12,
  parameter  int NUM_SLOTS    = 8,
  localparam int SLOT_W       = $clog2(NUM_SLOTS),
  localparam int CNT_W        = $clog2(NUM_SLOTS + 1)
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      req_in_valid,
  input  logic                      req_in_rw,
  input  logic [DATA_SIZE-1:0]      req_in_byteen,
  input  logic [ADDR_WIDTH-1:0]     req_in_addr,
  input  logic [8*DATA_SIZE-1:0]    req_in_data,
  input  logic [IN_TAG_WIDTH-1:0]   req_in_tag,
  output logic                      req_in_ready,

  output logic                      req_out_valid,
  output logic                      req_out_rw,
  output logic [DATA_SIZE-1:0]      req_out_byteen,
  output logic [ADDR_WIDTH-1:0]     req_out_addr,
  output logic [8*DATA_SIZE-1:0]    req_out_data,
  output logic [SLOT_W-1:0]         req_out_tag,
  input  logic                      req_out_ready,

  input  logic                      rsp_in_valid,
  input  logic [8*DATA_SIZE-1:0]    rsp_in_data,
  input  logic [SLOT_W-1:0]         rsp_in_tag,
  output logic                      rsp_in_ready,

  output logic                      rsp_out_valid,
  output logic [8*DATA_SIZE-1:0]    rsp_out_data,
  output logic [IN_TAG_WIDTH-1:0]   rsp_out_tag,
  input  logic                      rsp_out_ready,

  output logic [CNT_W-1:0]          pending,
  output logic                      tag_err
);

  logic [NUM_SLOTS-1:0]    busy_r;
  logic [IN_TAG_WIDTH-1:0] slot_tag_r [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]    busy_nxt_s;
  logic [NUM_SLOTS-1:0]    free_mask_s;
  logic [NUM_SLOTS-1:0]    alloc_mask_s;
  logic [SLOT_W-1:0]       alloc_slot_s;
  logic                    any_free_s;
  logic                    alloc_s;
  logic                    rsp_hs_s;

  function automatic logic [SLOT_W-1:0] lowest_free(input logic [NUM_SLOTS-1:0] busy);
    lowest_free = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        lowest_free = SLOT_W'(i);
      end else begin
        lowest_free = lowest_free;
      end
    end
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_SLOTS-1:0] v);
    popcount = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      popcount = popcount + CNT_W'(v[i]);
    end
  endfunction

  assign req_out_rw     = req_in_rw;
  assign req_out_byteen = req_in_byteen;
  assign req_out_addr   = req_in_addr;
  assign req_out_data   = req_in_data;

  // Allocator looks only at registered occupancy, so a slot freed this cycle waits a cycle.
  always_comb begin
    any_free_s   = ~&busy_r;
    alloc_slot_s = lowest_free(busy_r);
  end

  // Request handshake: writes bypass slot allocation entirely.
  always_comb begin
    req_out_valid = 1'b0;
    req_in_ready  = 1'b0;
    req_out_tag   = '0;
    if (req_in_rw) begin
      req_out_valid = req_in_valid;
      req_in_ready  = req_out_ready;
      req_out_tag   = '0;
    end else begin
      req_out_valid = req_in_valid & any_free_s;
      req_in_ready  = req_out_ready & any_free_s;
      req_out_tag   = alloc_slot_s;
    end
  end

  // Occupancy update: a free and an allocate never target the same busy slot.
  always_comb begin
    alloc_s      = req_out_valid & req_out_ready & ~req_in_rw;
    rsp_in_ready = ~rsp_out_valid | rsp_out_ready;
    rsp_hs_s     = rsp_in_valid & rsp_in_ready;
    free_mask_s  = rsp_hs_s ? (NUM_SLOTS'(1'b1) << rsp_in_tag) : '0;
    alloc_mask_s = alloc_s  ? (NUM_SLOTS'(1'b1) << alloc_slot_s) : '0;
    busy_nxt_s   = (busy_r & ~free_mask_s) | alloc_mask_s;
  end

  // Slot occupancy, occupied count and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r  <= '0;
      pending <= '0;
      tag_err <= 1'b0;
    end else begin
      busy_r  <= busy_nxt_s;
      pending <= popcount(busy_nxt_s);
      if (rsp_hs_s && !busy_r[rsp_in_tag]) begin
        tag_err <= 1'b1;
      end else begin
        tag_err <= tag_err;
      end
    end
  end

  // Slot table holds the original upstream tag; contents are meaningless while free.
  always_ff @(posedge clk) begin
    if (alloc_s) begin
      slot_tag_r[alloc_slot_s] <= req_in_tag;
    end else begin
      slot_tag_r[alloc_slot_s] <= slot_tag_r[alloc_slot_s];
    end
  end

  // Response output stage: loads on handshake, holds while upstream stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_out_valid <= 1'b0;
      rsp_out_data  <= '0;
      rsp_out_tag   <= '0;
    end else if (rsp_hs_s) begin
      rsp_out_valid <= 1'b1;
      rsp_out_data  <= rsp_in_data;
      rsp_out_tag   <= slot_tag_r[rsp_in_tag];
    end else if (rsp_out_ready) begin
      rsp_out_valid <= 1'b0;
    end else begin
      rsp_out_valid <= rsp_out_valid;
    end
  end

endmodule

// File: tb/tb_mem_tag_remap.sv
// Self-checking bench for mem_tag_remap: directed scenarios plus randomized
// traffic against an array-based slot model.
module tb_mem_tag_remap;
  localparam int AW = 26, DS = 64, TW = 12, NS = 8, SW = 3, CW = 4, DW = 512;

  logic clk = 1'b0;
  logic reset;
  logic req_in_valid, req_in_rw, req_in_ready;
  logic [DS-1:0] req_in_byteen;
  logic [AW-1:0] req_in_addr;
  logic [DW-1:0] req_in_data;
  logic [TW-1:0] req_in_tag;
  logic req_out_valid, req_out_rw, req_out_ready;
  logic [DS-1:0] req_out_byteen;
  logic [AW-1:0] req_out_addr;
  logic [DW-1:0] req_out_data;
  logic [SW-1:0] req_out_tag;
  logic rsp_in_valid, rsp_in_ready;
  logic [DW-1:0] rsp_in_data;
  logic [SW-1:0] rsp_in_tag;
  logic rsp_out_valid, rsp_out_ready;
  logic [DW-1:0] rsp_out_data;
  logic [TW-1:0] rsp_out_tag;
  logic [CW-1:0] pending;
  logic tag_err;

  always #5 clk = ~clk;

  mem_tag_remap dut (
    .clk(clk), .reset(reset),
    .req_in_valid(req_in_valid), .req_in_rw(req_in_rw), .req_in_byteen(req_in_byteen),
    .req_in_addr(req_in_addr), .req_in_data(req_in_data), .req_in_tag(req_in_tag),
    .req_in_ready(req_in_ready),
    .req_out_valid(req_out_valid), .req_out_rw(req_out_rw), .req_out_byteen(req_out_byteen),
    .req_out_addr(req_out_addr), .req_out_data(req_out_data), .req_out_tag(req_out_tag),
    .req_out_ready(req_out_ready),
    .rsp_in_valid(rsp_in_valid), .rsp_in_data(rsp_in_data), .rsp_in_tag(rsp_in_tag),
    .rsp_in_ready(rsp_in_ready),
    .rsp_out_valid(rsp_out_valid), .rsp_out_data(rsp_out_data), .rsp_out_tag(rsp_out_tag),
    .rsp_out_ready(rsp_out_ready),
    .pending(pending), .tag_err(tag_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: which slots hold an outstanding read and what tag each carries.
  bit            m_busy [NS];
  logic [TW-1:0] m_tbl  [NS];
  bit            m_rv;
  bit            m_rtag_known;
  logic [TW-1:0] m_rtag;
  logic [DW-1:0] m_rdata;
  bit            m_err;

  logic [SW-1:0] obs_tag;
  logic          obs_in_ready, obs_out_valid, obs_rsp_ready;

  task automatic check_val(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NS; i++) c += m_busy[i];
    return c;
  endfunction

  function automatic int m_lowest();
    for (int i = 0; i < NS; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NS; i++) m_busy[i] = 1'b0;
    m_rv = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic idle();
    req_in_valid = 1'b0; req_in_rw = 1'b0; req_out_ready = 1'b1;
    rsp_in_valid = 1'b0; rsp_in_tag = '0; rsp_out_ready = 1'b1;
  endtask

  task automatic fill_req(bit rw, logic [TW-1:0] tag);
    req_in_valid = 1'b1; req_in_rw = rw; req_in_tag = tag;
    req_in_addr = AW'($urandom); req_in_byteen = {$urandom, $urandom};
    for (int k = 0; k < 16; k++) req_in_data[k*32 +: 32] = $urandom;
  endtask

  task automatic fill_rsp(logic [SW-1:0] slot);
    rsp_in_valid = 1'b1; rsp_in_tag = slot;
    for (int k = 0; k < 16; k++) rsp_in_data[k*32 +: 32] = $urandom;
  endtask

  // One clock: check combinational paths at negedge, advance the model, check registers.
  task automatic step();
    int low;
    bit rsp_rdy, rsp_hs, alloc, exp_v, exp_r, out_rdy;
    logic [SW-1:0] rt;
    logic [TW-1:0] it;
    logic [DW-1:0] rd;
    @(negedge clk);
    low = m_lowest();
    rsp_rdy = !m_rv || rsp_out_ready;
    if (req_in_rw) begin
      exp_v = req_in_valid; exp_r = req_out_ready;
    end else begin
      exp_v = req_in_valid && (low >= 0); exp_r = req_out_ready && (low >= 0);
    end
    check_val("req_out_valid", req_out_valid, exp_v);
    check_val("req_in_ready", req_in_ready, exp_r);
    if (req_in_rw) check_val("req_out_tag_wr", req_out_tag, 0);
    else if (low >= 0) check_val("req_out_tag_rd", req_out_tag, low);
    check_val("req_passthru", {req_out_rw, req_out_byteen, req_out_addr},
              {req_in_rw, req_in_byteen, req_in_addr});
    check_val("req_out_data", req_out_data, req_in_data);
    check_val("rsp_in_ready", rsp_in_ready, rsp_rdy);
    obs_tag = req_out_tag; obs_in_ready = req_in_ready;
    obs_out_valid = req_out_valid; obs_rsp_ready = rsp_in_ready;
    rsp_hs = rsp_in_valid && rsp_rdy;
    alloc = !req_in_rw && req_in_valid && req_out_ready && (low >= 0);
    rt = rsp_in_tag; it = req_in_tag; rd = rsp_in_data; out_rdy = rsp_out_ready;
    @(posedge clk);
    if (rsp_hs) begin
      m_rv = 1'b1; m_rdata = rd;
      m_rtag_known = m_busy[rt]; m_rtag = m_tbl[rt];
      if (!m_busy[rt]) m_err = 1'b1;
      else m_busy[rt] = 1'b0;
    end else if (out_rdy) begin
      m_rv = 1'b0;
    end
    if (alloc) begin
      m_busy[low] = 1'b1; m_tbl[low] = it;
    end
    #1;
    check_val("rsp_out_valid", rsp_out_valid, m_rv);
    if (m_rv) check_val("rsp_out_data", rsp_out_data, m_rdata);
    if (m_rv && m_rtag_known) check_val("rsp_out_tag", rsp_out_tag, m_rtag);
    check_val("pending", pending, m_count());
    check_val("tag_err", tag_err, m_err);
  endtask

  task automatic rand_drive(bit allow_bad);
    int nb, pick;
    fill_req($urandom_range(0, 9) < 4, TW'($urandom));
    req_in_valid = $urandom_range(0, 3) != 0;
    req_out_ready = $urandom_range(0, 3) != 0;
    rsp_out_ready = $urandom_range(0, 3) != 0;
    fill_rsp('0);
    rsp_in_valid = 1'b0;
    nb = m_count();
    if (nb > 0 && $urandom_range(0, 1) == 1) begin
      pick = $urandom_range(0, nb - 1);
      for (int i = 0; i < NS; i++) begin
        if (m_busy[i]) begin
          if (pick == 0) begin rsp_in_valid = 1'b1; rsp_in_tag = SW'(i); end
          pick--;
        end
      end
    end
    if (allow_bad && $urandom_range(0, 7) == 0) begin
      rsp_in_valid = 1'b1; rsp_in_tag = SW'($urandom);
    end
  endtask

  initial begin
    idle();
    req_in_tag = '0; req_in_addr = '0; req_in_byteen = '0; req_in_data = '0; rsp_in_data = '0;
    reset = 1'b0;
    m_reset();
    #12;
    check_val("reset_pending", pending, 0);
    check_val("reset_rsp_valid", rsp_out_valid, 0);
    check_val("reset_tag_err", tag_err, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Fill every slot with back-to-back reads, then a ninth read must stall.
    for (int i = 0; i < NS; i++) begin
      fill_req(1'b0, TW'(12'h100 + i));
      step();
      check_val("fill_tag", obs_tag, i);
    end
    check_val("full_pending", pending, 8);
    fill_req(1'b0, 12'h108);
    step();
    check_val("full_read_stall", obs_in_ready, 0);

    // Writes still flow while full.
    fill_req(1'b1, 12'h3FF);
    step();
    check_val("full_write_tag", obs_tag, 0);
    check_val("full_write_valid", obs_out_valid, 1);
    check_val("full_write_pending", pending, 8);

    // Out-of-order responses restore the original tags.
    req_in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      automatic int s = (j == 0) ? 5 : (j == 1) ? 2 : 7;
      fill_rsp(SW'(s));
      step();
      check_val("ooo_rsp_tag", rsp_out_tag, 12'h100 + s);
    end
    check_val("ooo_pending", pending, 5);
    rsp_in_valid = 1'b0;
    fill_req(1'b0, 12'h200);
    step();
    check_val("realloc_slot", obs_tag, 2);

    // Upstream stall blocks a second response and holds the first.
    req_in_valid = 1'b0;
    rsp_out_ready = 1'b0;
    fill_rsp(3'd0);
    step();
    fill_rsp(3'd1);
    for (int j = 0; j < 3; j++) begin
      step();
      check_val("stall_rsp_ready", obs_rsp_ready, 0);
      check_val("stall_rsp_tag", rsp_out_tag, 12'h100);
      check_val("stall_pending", pending, 5);
    end
    rsp_out_ready = 1'b1;
    step();
    check_val("unstall_rsp_tag", rsp_out_tag, 12'h101);
    check_val("unstall_pending", pending, 4);

    // Refill, then allocate and free in the same cycle while full.
    rsp_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fill_req(1'b0, TW'(12'h300 + i));
      step();
    end
    check_val("refill_pending", pending, 8);
    fill_req(1'b0, 12'h3AA);
    fill_rsp(3'd0);
    step();
    check_val("same_cycle_no_grant", obs_in_ready, 0);
    check_val("same_cycle_pending", pending, 7);
    fill_rsp(3'd1);
    step();
    check_val("next_cycle_grant", obs_tag, 0);
    check_val("alloc_free_pending", pending, 7);

    // Response to a free slot raises the sticky error.
    req_in_valid = 1'b0;
    fill_rsp(3'd3);
    step();
    step();
    check_val("bad_rsp_err", tag_err, 1);
    check_val("bad_rsp_pending", pending, 6);
    rsp_in_valid = 1'b0;
    step();
    step();
    check_val("err_sticky", tag_err, 1);

    for (int c = 0; c < 1500; c++) begin
      rand_drive(1'b0);
      step();
    end

    // Asynchronous reset in the middle of traffic.
    rand_drive(1'b0);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check_val("async_rst_pending", pending, 0);
    check_val("async_rst_valid", rsp_out_valid, 0);
    check_val("async_rst_err", tag_err, 0);
    m_reset();
    idle();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    fill_rsp(3'd4);
    step();
    check_val("post_rst_err", tag_err, 1);

    for (int c = 0; c < 600; c++) begin
      rand_drive(1'b1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
